// File: rtl/bm_lpm_split.sv
// bm_lpm_split: checks and strips a constant tag, buffers payloads in a 2-entry FIFO, counts good and bad words
module bm_lpm_split #(
    parameter int             BITS  = 32,
    parameter int             TAG_W = 8,
    parameter logic [TAG_W-1:0] TAG = 8'h56,
    parameter int             CNT_W = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [BITS-1:0]       in_word,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BITS-TAG_W-1:0] out_payload,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  clear,
    output logic                  err_flag,
    output logic [CNT_W-1:0]      err_count,
    output logic [CNT_W-1:0]      good_count
);
    localparam int PW = BITS - TAG_W;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t          r_state, w_next;
    logic [PW-1:0]   r_q0, r_q1;
    logic            r_err_flag;
    logic [CNT_W-1:0] r_err_count, r_good_count;
    logic            w_acc, w_good, w_bad, w_pop;

    assign w_acc  = in_valid & in_ready;
    assign w_good = w_acc & (in_word[BITS-1:PW] == TAG);
    assign w_bad  = w_acc & (in_word[BITS-1:PW] != TAG);
    assign w_pop  = out_valid & out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= EMPTY;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            EMPTY:   w_next = w_good ? ONE : EMPTY;
            ONE:     w_next = (w_good & ~w_pop) ? FULL : (~w_good & w_pop) ? EMPTY : ONE;
            FULL:    w_next = w_pop ? ONE : FULL;
            default: w_next = EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = (r_state != FULL);
        out_valid = (r_state != EMPTY);
    end

    // q0 is always the head; a pop from FULL shifts q1 forward
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q0 <= '0;
            r_q1 <= '0;
        end else begin
            if (w_good && (r_state == EMPTY || (r_state == ONE && w_pop)))
                r_q0 <= in_word[PW-1:0];
            else if (r_state == FULL && w_pop)
                r_q0 <= r_q1;
            if (w_good && r_state == ONE && !w_pop)
                r_q1 <= in_word[PW-1:0];
        end
    end

    // clear wins over a same-cycle accept; counters saturate at all-ones
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_err_flag   <= 1'b0;
            r_err_count  <= '0;
            r_good_count <= '0;
        end else if (clear) begin
            r_err_flag   <= 1'b0;
            r_err_count  <= '0;
            r_good_count <= '0;
        end else begin
            if (w_bad) r_err_flag <= 1'b1;
            if (w_bad && r_err_count != '1) r_err_count <= r_err_count + 1'b1;
            if (w_good && r_good_count != '1) r_good_count <= r_good_count + 1'b1;
        end
    end

    assign out_payload = r_q0;
    assign err_flag    = r_err_flag;
    assign err_count   = r_err_count;
    assign good_count  = r_good_count;
endmodule

// File: tb/tb_bm_lpm_split.sv
// tb_bm_lpm_split: directed vectors with hand-computed expectations for bm_lpm_split
module tb_bm_lpm_split;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] in_word = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] out_payload;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        clear = 1'b0;
    logic        err_flag;
    logic [7:0]  err_count;
    logic [7:0]  good_count;

    int n_checks = 0;
    int n_fail   = 0;

    bm_lpm_split dut (
        .clock(clock), .reset_n(reset_n), .in_word(in_word), .in_valid(in_valid),
        .in_ready(in_ready), .out_payload(out_payload), .out_valid(out_valid),
        .out_ready(out_ready), .clear(clear), .err_flag(err_flag),
        .err_count(err_count), .good_count(good_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_payload", 32'(out_payload), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_err_flag", 32'(err_flag), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_good_count", 32'(good_count), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // good word, one-cycle latency
        out_ready = 1'b1;
        in_valid = 1'b1; in_word = 32'h56ABCDEF;
        tick();
        in_valid = 1'b0;
        check("good_valid", 32'(out_valid), 32'd1);
        check("good_payload", 32'(out_payload), 32'h00ABCDEF);
        check("good_count1", 32'(good_count), 32'd1);
        check("good_err_flag", 32'(err_flag), 32'd0);
        tick();
        check("good_popped", 32'(out_valid), 32'd0);

        // bad tag dropped
        in_valid = 1'b1; in_word = 32'h57000001;
        tick();
        in_valid = 1'b0;
        check("bad_valid", 32'(out_valid), 32'd0);
        check("bad_err_flag", 32'(err_flag), 32'd1);
        check("bad_err_count", 32'(err_count), 32'd1);
        check("bad_in_ready", 32'(in_ready), 32'd1);

        // backpressure and ordering
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_good", 32'(good_count), 32'd0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_word = 32'h56000001;
        tick();
        in_word = 32'h56000002;
        tick();
        in_word = 32'h56000003;
        check("bp_full_ready", 32'(in_ready), 32'd0);
        tick();
        check("bp_hold_ready", 32'(in_ready), 32'd0);
        check("bp_hold_head", 32'(out_payload), 32'h000001);
        out_ready = 1'b1;
        tick();
        check("bp_pop2", 32'(out_payload), 32'h000002);
        check("bp_ready_again", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_pop3", 32'(out_payload), 32'h000003);
        check("bp_pop3_valid", 32'(out_valid), 32'd1);
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_good3", 32'(good_count), 32'd3);

        // full throughput stream
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_word = 32'h56000010 + 32'(i);
            tick();
            check("tp_valid", 32'(out_valid), 32'd1);
            check("tp_payload", 32'(out_payload), 32'h000010 + 32'(i));
        end
        in_valid = 1'b0;
        tick();

        // saturation
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b1; in_word = 32'h58000000;
        repeat (300) tick();
        check("sat_err", 32'(err_count), 32'd255);
        tick();
        check("sat_hold", 32'(err_count), 32'd255);
        check("sat_good", 32'(good_count), 32'd0);
        check("sat_empty", 32'(out_valid), 32'd0);
        in_valid = 1'b0;

        // clear beats a same-cycle bad accept, FIFO untouched
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b1;
        repeat (5) tick();
        check("clr_err5", 32'(err_count), 32'd5);
        out_ready = 1'b0;
        in_word = 32'h56000077;
        tick();
        in_word = 32'h59000000; clear = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        check("clr_err0", 32'(err_count), 32'd0);
        check("clr_flag0", 32'(err_flag), 32'd0);
        check("clr_good0", 32'(good_count), 32'd0);
        check("clr_fifo_valid", 32'(out_valid), 32'd1);
        check("clr_fifo_head", 32'(out_payload), 32'h000077);

        // mid-cycle async reset while full
        in_valid = 1'b1; in_word = 32'h56000088;
        tick();
        in_valid = 1'b0;
        check("full_ready", 32'(in_ready), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_payload", 32'(out_payload), 32'd0);
        #1 reset_n = 1'b1;
        tick();
        check("post_rst_empty", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_word = 32'h56000042;
        tick();
        in_valid = 1'b0;
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_payload", 32'(out_payload), 32'h000042);
        out_ready = 1'b1;
        tick();
        check("post_rst_only", 32'(out_valid), 32'd0);
        check("post_rst_good", 32'(good_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
